// File: rtl/inmux_cmd_seq.sv
// inmux_cmd_seq: queued command sequencer issuing control tokens to the input-mux stage
module inmux_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_sel,
  input  logic [CNT_W-1:0]         cmd_count,
  input  logic                     halt,
  output logic [3:0]               sel,
  output logic                     t_c_req,
  input  logic                     t_c_ack,
  output logic                     cmd_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_sel
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [3:0] sel_m [DEPTH];
  logic [CNT_W-1:0] cnt_m [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W:0] remaining;
  logic [3:0] head_sel;
  logic [CNT_W-1:0] head_cnt;
  logic push, pop, last, head_legal;
  assign head_sel = sel_m[rd_ptr];
  assign head_cnt = cnt_m[rd_ptr];
  assign head_legal = head_sel == 4'd1 || head_sel == 4'd5 || head_sel == 4'd7;
  assign busy = state == RUN;
  assign t_c_req = busy;
  assign cmd_ready = fifo_level != (AW+1)'(DEPTH);
  assign push = cmd_valid && cmd_ready && !reset;
  assign last = busy && t_c_ack && remaining == (CNT_W+1)'(1);
  // a finishing command hands over to the next queued one at the same edge
  assign pop = fifo_level != '0 && !halt && (!busy || last) && !reset;
  always_comb state_nx = pop ? RUN : last ? IDLE : state;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (push) begin
      sel_m[wr_ptr] <= cmd_sel;
      cnt_m[wr_ptr] <= cmd_count;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      sel        <= '0;
      remaining  <= '0;
      cmd_done   <= 1'b0;
      err_sel    <= 1'b0;
    end else begin
      cmd_done   <= last;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        sel       <= head_sel;
        remaining <= {head_cnt == '0, head_cnt};
        if (!head_legal) err_sel <= 1'b1;
      end else if (busy && t_c_ack) begin
        remaining <= remaining - (CNT_W+1)'(1);
      end
    end
  end
endmodule
